// File: rtl/bounded_up_down_counter.sv
// bounded_up_down_counter: up/down counter with programmable bounds, variable step, load, wrap/saturate
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   en         count enable
//   up_down    1 = up, 0 = down
//   step       unsigned step amount
//   load       parallel load strobe (highest priority)
//   load_val   value to load, clamped into [MIN_VAL,MAX_VAL]
//   clr_flags  clears the sticky flags (a same-cycle crossing wins)
//   count      registered count
//   at_max     count == MAX_VAL
//   at_min     count == MIN_VAL
//   bound_hit  one-cycle pulse after a wrap or clamp
//   ovf_sticky set on an upward bound crossing
//   unf_sticky set on a downward bound crossing
module bounded_up_down_counter #(
  parameter int N        = 8,
  parameter int STEP_W   = 4,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 255,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [N-1:0]      load_val,
  input  logic              clr_flags,
  output logic [N-1:0]      count,
  output logic              at_max,
  output logic              at_min,
  output logic              bound_hit,
  output logic              ovf_sticky,
  output logic              unf_sticky
);
  localparam int RANGE = MAX_VAL - MIN_VAL + 1;
  localparam logic signed [N+1:0] MAX_S = (N+2)'(MAX_VAL);
  localparam logic signed [N+1:0] MIN_S = (N+2)'(MIN_VAL);
  localparam logic signed [N+1:0] RNG_S = (N+2)'(RANGE);
  if (!(MIN_VAL < MAX_VAL && (2**STEP_W) - 1 < RANGE)) begin : g_chk
    $error("bounded_up_down_counter: need MIN_VAL < MAX_VAL and 2**STEP_W-1 < RANGE");
  end
  logic [N-1:0] count_q, count_d;
  logic hit_q, hit_d, ovf_q, ovf_d, unf_q, unf_d, ovf, unf;
  // N+2 signed bits hold count+step and count-step without truncation
  logic signed [N+1:0] cnt_s, stp_s, up_s, dn_s, ld_s, nxt_s;
  always_comb begin
    cnt_s = $signed({2'b00, count_q});
    stp_s = $signed((N+2)'(step));
    up_s  = cnt_s + stp_s;
    dn_s  = cnt_s - stp_s;
    ld_s  = $signed({2'b00, load_val});
    ovf   = ~load & en & up_down & (up_s > MAX_S);
    unf   = ~load & en & ~up_down & (dn_s < MIN_S);
    nxt_s = load ? (ld_s < MIN_S ? MIN_S : ld_s > MAX_S ? MAX_S : ld_s) :
            up_down ? (ovf ? (SATURATE != 0 ? MAX_S : up_s - RNG_S) : up_s) :
                      (unf ? (SATURATE != 0 ? MIN_S : dn_s + RNG_S) : dn_s);
    count_d = (load | en) ? nxt_s[N-1:0] : count_q;
    hit_d   = ovf | unf;
    ovf_d   = ovf | (ovf_q & ~clr_flags);
    unf_d   = unf | (unf_q & ~clr_flags);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= N'(MIN_VAL);
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign count      = count_q;
  assign at_max     = count_q == N'(MAX_VAL);
  assign at_min     = count_q == N'(MIN_VAL);
  assign bound_hit  = hit_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
endmodule

// File: tb/tb_bounded_up_down_counter.sv
// tb_bounded_up_down_counter: table-driven scoreboard bench for wrap and saturate instances
module tb_bounded_up_down_counter;
  logic clk = 0, reset = 0, en = 0, up_down = 0, load = 0, clr_flags = 0;
  logic [2:0] step = 0;
  logic [3:0] load_val = 0;
  logic [3:0] cw, cs;
  logic amxw, amnw, hw, ow, uw, amxs, amns, hs, os, us;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  bounded_up_down_counter #(.N(4), .STEP_W(3), .MIN_VAL(2), .MAX_VAL(11), .SATURATE(0)) u_w (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(cw), .at_max(amxw), .at_min(amnw),
    .bound_hit(hw), .ovf_sticky(ow), .unf_sticky(uw));
  bounded_up_down_counter #(.N(4), .STEP_W(3), .MIN_VAL(2), .MAX_VAL(11), .SATURATE(1)) u_s (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(cs), .at_max(amxs), .at_min(amns),
    .bound_hit(hs), .ovf_sticky(os), .unf_sticky(us));
  typedef struct packed {
    logic ld, en, ud;
    logic [2:0] st;
    logic [3:0] lv;
    logic clr;
    logic [3:0] cnt;
    logic hit, ovf, unf, amax, amin;
  } vec_t;
  vec_t sb[$];
  vec_t wt[17];
  vec_t st[7];
  function automatic vec_t mk(logic ld, logic e, logic ud, logic [2:0] s, logic [3:0] lv,
                              logic clr, logic [3:0] cnt, logic hit, logic ovf, logic unf);
    return '{ld, e, ud, s, lv, clr, cnt, hit, ovf, unf, cnt == 4'd11, cnt == 4'd2};
  endfunction
  task automatic chk(input bit s, input string nm);
    vec_t e;
    logic [8:0] a;
    e = sb.pop_front();
    a = s ? {cs, hs, os, us, amxs, amns} : {cw, hw, ow, uw, amxw, amnw};
    nvec++;
    if (a !== e[8:0]) begin
      nerr++;
      $display("FAIL %s: got cnt/hit/ovf/unf/max/min=%b want %b", nm, a, e[8:0]);
    end
  endtask
  task automatic apply(input vec_t v, input bit s, input string nm);
    load = v.ld; en = v.en; up_down = v.ud; step = v.st; load_val = v.lv; clr_flags = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    chk(s, nm);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    //             ld e ud st  lv  clr cnt hit ovf unf
    wt[0]  = mk(1, 0, 0, 0,  7, 0,  7, 0, 0, 0);
    wt[1]  = mk(0, 1, 1, 3,  0, 0, 10, 0, 0, 0);
    wt[2]  = mk(0, 1, 1, 3,  0, 0,  3, 1, 1, 0);
    wt[3]  = mk(0, 1, 0, 2,  0, 0, 11, 1, 1, 1);
    wt[4]  = mk(0, 0, 0, 0,  0, 0, 11, 0, 1, 1);
    wt[5]  = mk(1, 1, 1, 3, 15, 0, 11, 0, 1, 1);
    wt[6]  = mk(1, 0, 0, 0,  0, 0,  2, 0, 1, 1);
    wt[7]  = mk(0, 1, 1, 0,  0, 0,  2, 0, 1, 1);
    wt[8]  = mk(0, 1, 0, 0,  0, 0,  2, 0, 1, 1);
    wt[9]  = mk(0, 0, 0, 0,  0, 1,  2, 0, 0, 0);
    wt[10] = mk(1, 0, 0, 0, 10, 0, 10, 0, 0, 0);
    wt[11] = mk(0, 1, 1, 3,  0, 1,  3, 1, 1, 0);
    wt[12] = mk(0, 1, 0, 1,  0, 1,  2, 0, 0, 0);
    wt[13] = mk(0, 1, 0, 7,  0, 0,  5, 1, 0, 1);
    wt[14] = mk(0, 1, 1, 7,  0, 0,  2, 1, 1, 1);
    wt[15] = mk(0, 1, 1, 7,  0, 0,  9, 0, 1, 1);
    wt[16] = mk(0, 1, 1, 2,  0, 0, 11, 0, 1, 1);
    st[0]  = mk(1, 0, 0, 0, 10, 0, 10, 0, 0, 0);
    st[1]  = mk(0, 1, 1, 3,  0, 0, 11, 1, 1, 0);
    st[2]  = mk(0, 1, 1, 3,  0, 0, 11, 1, 1, 0);
    st[3]  = mk(0, 1, 0, 7,  0, 0,  4, 0, 1, 0);
    st[4]  = mk(0, 1, 0, 3,  0, 0,  2, 1, 1, 1);
    st[5]  = mk(0, 1, 0, 1,  0, 0,  2, 1, 1, 1);
    st[6]  = mk(0, 0, 0, 0,  0, 0,  2, 0, 1, 1);
    #12;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    chk(0, "reset_wrap");
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    chk(1, "reset_sat");
    reset = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) apply(wt[i], 0, $sformatf("wrap%0d", i));
    apply(mk(1, 0, 0, 0, 7, 0, 7, 0, 1, 1), 0, "load7");
    load = 0;
    #3;
    reset = 0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    chk(0, "async_reset");
    reset = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) apply(st[i], 1, $sformatf("sat%0d", i));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
